divider_control: RTL and testbench
==================================

DIVIDER_CONTROL -- requirements
Module: divider_control

Interface
REQ-001 The block SHALL have one parameter: ITER, default 32, number of subtract/shift iterations (equal to the dividend width).
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new division; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous cancel of an operation in progress.
REQ-006 The block SHALL have port divisor_zero, input, 1 bit: divisor == 0 flag from the datapath; sampled with start.
REQ-007 The block SHALL have port W_ctrl, output, 1 bit: remainder-register load of {ALU_result, dividend}.
REQ-008 The block SHALL have port SLL_ctrl, output, 1 bit: remainder-register shift-left, ALU_carry into the LSB.
REQ-009 The block SHALL have port SRL_ctrl, output, 1 bit: remainder-register upper-half shift-right fixup.
REQ-010 The block SHALL have port ALU_op, output, 2 bits: 00 ZERO (result 0, carry 0); 01 PASS (result = remainder high half, carry 0); 10 SUB (restoring subtract; carry 1 if no borrow); 11 reserved, never driven.
REQ-011 The block SHALL have port ready, output, 1 bit: high in IDLE only.
REQ-012 The block SHALL have port busy, output, 1 bit: high in LOAD, SHIFT, ITER and FIX.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port dz, output, 1 bit: divide-by-zero status, valid while done is high.
REQ-015 The block SHALL have port iter_cnt, output, $clog2(ITER)+1 bits: count of completed ITER cycles.

Function
REQ-016 The block SHALL implement the states IDLE, LOAD, SHIFT, ITER, FIX and DONE, with all outputs decoded from the state register and iteration counter only (Moore; no input-to-output combinational path).
REQ-017 In IDLE, when start=1 at an edge: if divisor_zero=1, next state SHALL be DONE with dz latched to 1; otherwise next state SHALL be LOAD with dz latched to 0.
REQ-018 In IDLE with start=0, state SHALL hold and all control outputs SHALL be 0.
REQ-019 In LOAD, W_ctrl SHALL be 1 and ALU_op SHALL be ZERO for exactly one cycle; next state SHALL be SHIFT.
REQ-020 In SHIFT, SLL_ctrl SHALL be 1 and ALU_op SHALL be PASS for exactly one cycle; next state SHALL be ITER and iter_cnt SHALL be cleared to 0.
REQ-021 In ITER, SLL_ctrl SHALL be 1, ALU_op SHALL be SUB, and iter_cnt SHALL increment each cycle; after exactly ITER cycles (iter_cnt reaches ITER) next state SHALL be FIX.
REQ-022 In FIX, SRL_ctrl SHALL be 1 and ALU_op SHALL be PASS for exactly one cycle; next state SHALL be DONE.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle; next state SHALL be IDLE and start SHALL be ignored in that cycle.
REQ-024 At most one of W_ctrl, SLL_ctrl and SRL_ctrl SHALL be high in any cycle; all three SHALL be 0 in IDLE and DONE.
REQ-025 Latency: with start accepted at edge 0, LOAD SHALL occupy cycle 1, SHIFT cycle 2, ITER cycles 3..ITER+2, FIX cycle ITER+3, and DONE cycle ITER+4 (cycle 36 for ITER=32); the divide-by-zero path SHALL reach DONE in cycle 1.
REQ-026 When abort=1 in LOAD, SHIFT, ITER or FIX, next state SHALL be IDLE with no done pulse, dz cleared and iter_cnt cleared.
REQ-027 Abort SHALL be ignored in IDLE and DONE.
REQ-028 When start and abort are both high in IDLE, abort SHALL be ignored and start SHALL be honoured.
REQ-029 start held continuously high SHALL launch back-to-back operations separated by exactly one IDLE cycle.
REQ-030 The iteration counter SHALL never wrap; values above ITER SHALL be unreachable.

Reset
REQ-031 Reset=1 SHALL immediately force IDLE, iter_cnt=0 and dz=0, and SHALL drive W_ctrl, SLL_ctrl, SRL_ctrl and done to 0, ALU_op to 00, busy to 0 and ready to 1, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL discard the operation with no done pulse, and the first start after Reset deasserts SHALL be accepted normally.

Verification
REQ-033 Nominal case: start=1 for one cycle, divisor_zero=0 -> W_ctrl at cycle 1; SLL_ctrl at cycles 2..34 (33 cycles total); SRL_ctrl at cycle 35; done=1 and dz=0 at cycle 36; ready=1 at cycle 37.
REQ-034 Divide-by-zero: start=1 with divisor_zero=1 -> no W_ctrl/SLL_ctrl/SRL_ctrl ever asserted; done=1 and dz=1 at cycle 1; IDLE at cycle 2.
REQ-035 Abort: abort=1 at cycle 10 (ITER, iter_cnt=7) -> IDLE at cycle 11, done never asserted, iter_cnt=0.
REQ-036 Asynchronous reset: Reset pulsed between clock edges during ITER -> outputs go to reset values before the next edge; a subsequent start completes in 36 cycles.
REQ-037 Back-to-back and one-hot check: start held high for 80 cycles -> done at cycles 36 and 73; one-hot check on W/SLL/SRL passes every cycle; start during the DONE cycle has no effect.

Source files
------------

// File: rtl/divider_control.sv
// Sequencer for a restoring shift/subtract divider: LOAD, SHIFT, ITER x ITER, FIX, DONE.
// Done pulses ITER+4 cycles after start (1 cycle on divide-by-zero); start is sampled only in IDLE.
module divider_control #(
    parameter int ITER = 32
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    divisor_zero,
    output logic                    W_ctrl,
    output logic                    SLL_ctrl,
    output logic                    SRL_ctrl,
    output logic [1:0]              ALU_op,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic                    dz,
    output logic [$clog2(ITER):0]   iter_cnt
);

    localparam int CW = $clog2(ITER) + 1;

    localparam logic [1:0]    OP_ZERO  = 2'b00;
    localparam logic [1:0]    OP_PASS  = 2'b01;
    localparam logic [1:0]    OP_SUB   = 2'b10;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(ITER);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_ITER  = 3'd3,
        S_FIX   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dz_q, dz_d;
    logic            abortable;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    assign abortable = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                       (state_q == S_ITER) || (state_q == S_FIX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dz_d    = divisor_zero;
                    state_d = divisor_zero ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: begin
                state_d = S_ITER;
                cnt_d   = '0;
            end
            S_ITER: begin
                // Saturating guard keeps the counter from ever passing ITER.
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (cnt_q >= CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && abortable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dz_d    = 1'b0;
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        W_ctrl   = 1'b0;
        SLL_ctrl = 1'b0;
        SRL_ctrl = 1'b0;
        ALU_op   = OP_ZERO;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE:  ready = 1'b1;
            S_LOAD: begin
                W_ctrl = 1'b1;
                ALU_op = OP_ZERO;
                busy   = 1'b1;
            end
            S_SHIFT: begin
                SLL_ctrl = 1'b1;
                ALU_op   = OP_PASS;
                busy     = 1'b1;
            end
            S_ITER: begin
                SLL_ctrl = 1'b1;
                ALU_op   = OP_SUB;
                busy     = 1'b1;
            end
            S_FIX: begin
                SRL_ctrl = 1'b1;
                ALU_op   = OP_PASS;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign dz       = dz_q;
    assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_divider_control.sv
// Directed bench for divider_control: table of per-cycle expectations plus hand-written corner sequences.
module tb_divider_control;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       divisor_zero = 1'b0;
    logic       W_ctrl, SLL_ctrl, SRL_ctrl, ready, busy, done, dz;
    logic [1:0] ALU_op;
    logic [5:0] iter_cnt;

    divider_control #(.ITER(32)) dut (
        .clk(clk), .Reset(Reset), .start(start), .abort(abort),
        .divisor_zero(divisor_zero), .W_ctrl(W_ctrl), .SLL_ctrl(SLL_ctrl),
        .SRL_ctrl(SRL_ctrl), .ALU_op(ALU_op), .ready(ready), .busy(busy),
        .done(done), .dz(dz), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic       sll;
        logic       srl;
        logic [1:0] op;
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic       dzv;
        logic [5:0] cnt;
    } out_t;

    typedef struct {
        int   scen;
        int   cyc;
        out_t exp;
        out_t msk;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   n_w, n_sll, n_srl, n_done;
    int   cyc;
    out_t obs [2][0:40];
    vec_t vec [$];

    function automatic out_t mk(logic w, logic sll, logic srl, logic [1:0] op,
                                logic rdy, logic bsy, logic dn, logic dzv, logic [5:0] cnt);
        mk = {w, sll, srl, op, rdy, bsy, dn, dzv, cnt};
    endfunction

    function automatic out_t cur();
        cur = {W_ctrl, SLL_ctrl, SRL_ctrl, ALU_op, ready, busy, done, dz, iter_cnt};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: advance past the edge, then tally strobes and check one-hotness.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        n_w    += int'(W_ctrl);
        n_sll  += int'(SLL_ctrl);
        n_srl  += int'(SRL_ctrl);
        n_done += int'(done);
        chk($sformatf("onehot_c%0d", cyc), int'(W_ctrl) + int'(SLL_ctrl) + int'(SRL_ctrl) <= 1, 1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        divisor_zero = 1'b0;
        #1;
        chk("reset_state", int'(cur()), int'(mk(0,0,0,2'b00,1,0,0,0,6'd0)));
        @(posedge clk);
        #1;
        Reset = 1'b0;
        cyc = 0; n_w = 0; n_sll = 0; n_srl = 0; n_done = 0;
    endtask

    task automatic launch(input logic dzin, input logic ab);
        start = 1'b1;
        divisor_zero = dzin;
        abort = ab;
        step();
        start = 1'b0;
        divisor_zero = 1'b0;
    endtask

    task automatic run_scen(input int s, input logic dzin);
        do_reset();
        obs[s][0] = cur();
        launch(dzin, 1'b0);
        obs[s][1] = cur();
        for (int c = 2; c <= 40; c++) begin
            step();
            obs[s][c] = cur();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t full, nodz;
        int   first, second, lat;
        full = '1;
        nodz = mk(1,1,1,2'b11,1,1,1,0,6'h3f);

        // scen 0: nominal division, scen 1: divide by zero
        vec.push_back('{0,  0, mk(0,0,0,2'b00,1,0,0,0,6'd0),  full});
        vec.push_back('{0,  1, mk(1,0,0,2'b00,0,1,0,0,6'd0),  full});
        vec.push_back('{0,  2, mk(0,1,0,2'b01,0,1,0,0,6'd0),  full});
        vec.push_back('{0,  3, mk(0,1,0,2'b10,0,1,0,0,6'd0),  full});
        vec.push_back('{0, 10, mk(0,1,0,2'b10,0,1,0,0,6'd7),  full});
        vec.push_back('{0, 34, mk(0,1,0,2'b10,0,1,0,0,6'd31), full});
        vec.push_back('{0, 35, mk(0,0,1,2'b01,0,1,0,0,6'd32), full});
        vec.push_back('{0, 36, mk(0,0,0,2'b00,0,0,1,0,6'd32), full});
        vec.push_back('{0, 37, mk(0,0,0,2'b00,1,0,0,0,6'd32), full});
        vec.push_back('{1,  1, mk(0,0,0,2'b00,0,0,1,1,6'd0),  full});
        vec.push_back('{1,  2, mk(0,0,0,2'b00,1,0,0,0,6'd0),  nodz});
        vec.push_back('{1,  3, mk(0,0,0,2'b00,1,0,0,0,6'd0),  nodz});

        run_scen(0, 1'b0);
        chk("nom_w_count",    n_w,    1);
        chk("nom_sll_count",  n_sll,  33);
        chk("nom_srl_count",  n_srl,  1);
        chk("nom_done_count", n_done, 1);
        run_scen(1, 1'b1);
        chk("dz_strobe_count", n_w + n_sll + n_srl, 0);
        chk("dz_done_count",   n_done, 1);

        foreach (vec[i]) begin
            chk($sformatf("vec_s%0d_c%0d", vec[i].scen, vec[i].cyc),
                int'(obs[vec[i].scen][vec[i].cyc] & vec[i].msk),
                int'(vec[i].exp & vec[i].msk));
        end

        // Abort during ITER
        do_reset();
        launch(1'b0, 1'b0);
        while (cyc < 10) step();
        chk("abort_pre_cnt", int'(iter_cnt), 7);
        chk("abort_pre_op",  int'(ALU_op),   2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", int'(cur()), int'(mk(0,0,0,2'b00,1,0,0,0,6'd0)));
        n_done = 0;
        repeat (40) step();
        chk("abort_no_done", n_done, 0);

        // Abort ignored in IDLE; start wins over abort
        abort = 1'b1;
        repeat (3) step();
        chk("abort_in_idle", int'(ready), 1);
        launch(1'b0, 1'b1);
        abort = 1'b0;
        chk("start_over_abort_w",    int'(W_ctrl), 1);
        chk("start_over_abort_busy", int'(busy),   1);
        repeat (40) step();
        launch(1'b1, 1'b1);
        chk("dz_with_abort_done", int'(done), 1);
        chk("dz_with_abort_dz",   int'(dz),   1);
        step();
        abort = 1'b0;
        chk("dz_with_abort_idle", int'(ready), 1);

        // Asynchronous reset mid-ITER
        do_reset();
        launch(1'b0, 1'b0);
        while (cyc < 12) step();
        chk("pre_areset_busy", int'(busy), 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("areset_outputs", int'(cur()), int'(mk(0,0,0,2'b00,1,0,0,0,6'd0)));
        #1;
        Reset = 1'b0;
        n_done = 0;
        repeat (40) step();
        chk("areset_no_done", n_done, 0);
        launch(1'b0, 1'b0);
        lat = 0;
        for (int c = 2; c <= 60; c++) begin
            step();
            if (done && lat == 0) lat = c;
        end
        chk("areset_relaunch_latency", lat, 36);

        // start held high: back-to-back operations
        do_reset();
        first = 0;
        second = 0;
        start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            step();
            if (done) begin
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
        end
        start = 1'b0;
        chk("b2b_first_done",  first,  36);
        chk("b2b_second_done", second, 73);
        chk("b2b_done_count",  n_done, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
